// File: rtl/pe_dil_pkg.sv
// Shared Dilithium coefficient types, pipeline stage record and the
// Barrett reduction mod Q used by the shared multiplier.
package pe_dil_pkg;

  localparam logic [22:0] Q         = 23'd8380417;
  localparam int unsigned COEF_W    = 23;
  localparam int unsigned PROD_W    = 46;
  localparam int unsigned ID_MAX_W  = 3;
  localparam int unsigned BARRETT_K = 46;
  localparam logic [23:0] BARRETT_M = 24'((70'd1 << BARRETT_K) / 70'(Q));

  typedef logic [COEF_W-1:0] coef_t;
  typedef logic [PROD_W-1:0] prod_t;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    prod_t               payload;
  } stage_t;

  // red_D: product < 2^46, so the quotient estimate is at most 2 low.
  function automatic coef_t red_d(input prod_t p);
    logic [69:0] t;
    logic [23:0] q_est;
    logic [47:0] r;
    t     = 70'(p) * 70'(BARRETT_M);
    q_est = 24'(t >> BARRETT_K);
    r     = 48'(p) - 48'(q_est) * 48'(Q);
    if (r >= 48'(Q)) r = r - 48'(Q);
    if (r >= 48'(Q)) r = r - 48'(Q);
    return COEF_W'(r);
  endfunction

endpackage

// File: rtl/rr_arb_n.sv
// Round-robin arbiter: combinational grant from a rotating search start,
// pointer advances past the winner only when the grant is taken.
module rr_arb_n #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] gnt_idx_c,
  output logic          gnt_any_c
);

  logic [IW-1:0] ptr;

  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    gnt_any_c = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned k;
      k = (32'(ptr) + i) % N;
      if (!gnt_any_c && req[IW'(k)]) begin
        gnt_any_c = 1'b1;
        gnt_idx_c = IW'(k);
      end
    end
    if (adv && gnt_any_c) gnt_c[gnt_idx_c] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv && gnt_any_c) begin
      ptr <= (gnt_idx_c == IW'(N - 1)) ? '0 : gnt_idx_c + IW'(1);
    end
  end

endmodule

// File: rtl/mulred_sched_d.sv
// Shared pipelined a*b mod Q unit: round-robin request arbitration, three
// tagged stages (operands, product, reduced result) and one global stall.
module mulred_sched_d
  import pe_dil_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [N_REQ-1:0]      req_valid_i,
  input  logic [N_REQ*23-1:0]   req_a_i,
  input  logic [N_REQ*23-1:0]   req_b_i,
  output logic [N_REQ-1:0]      req_ready_o,
  output logic                  rsp_valid_o,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic [22:0]           rsp_data_o,
  input  logic                  rsp_ready_i,
  output logic                  busy_o
);

  stage_t          s0, s1, s2;
  logic            advance_c;
  logic [N_REQ-1:0] gnt_c;
  logic [ID_W-1:0] gnt_idx_c;
  logic            gnt_any_c;
  coef_t           a_sel_c, b_sel_c;

  // Whole pipeline moves together; it only stops when a result is refused.
  assign advance_c = ~s2.valid | rsp_ready_i;

  rr_arb_n #(.N(N_REQ), .IW(ID_W)) u_arb (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .req       (req_valid_i),
    .adv       (advance_c),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c),
    .gnt_any_c (gnt_any_c)
  );

  always_comb begin
    a_sel_c = '0;
    b_sel_c = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt_idx_c == ID_W'(k)) begin
        a_sel_c = req_a_i[k*COEF_W +: COEF_W];
        b_sel_c = req_b_i[k*COEF_W +: COEF_W];
      end
    end
  end

  assign req_ready_o = rst_n_i ? gnt_c : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
    end else if (advance_c) begin
      s0 <= '{valid: gnt_any_c, id: ID_MAX_W'(gnt_idx_c), payload: {a_sel_c, b_sel_c}};
      s1 <= '{valid: s0.valid, id: s0.id,
              payload: PROD_W'(s0.payload[45:23]) * PROD_W'(s0.payload[22:0])};
      s2 <= '{valid: s1.valid, id: s1.id, payload: PROD_W'(red_d(s1.payload))};
    end
  end

  assign rsp_valid_o = s2.valid;
  assign rsp_id_o    = ID_W'(s2.id);
  assign rsp_data_o  = COEF_W'(s2.payload);
  assign busy_o      = s0.valid | s1.valid | s2.valid;

  // Out-of-range operands give undefined results; flag them on acceptance.
  a_operand_range: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (advance_c && gnt_any_c) |-> (a_sel_c < Q && b_sel_c < Q));

endmodule
